// File: rtl/dc_mem_pkg.sv
// Shared types for the DC-stage data-memory sequencer: FSM states, bus size codes
// and the captured request record.
package dc_mem_pkg;

    typedef enum logic [2:0] {
        DC_MEM_IDLE  = 3'd0,
        DC_MEM_REQ   = 3'd1,
        DC_MEM_WAIT  = 3'd2,
        DC_MEM_DONE  = 3'd3,
        DC_MEM_DRAIN = 3'd4
    } dc_mem_state_e;

    localparam logic [1:0] SizeByte = 2'd0;
    localparam logic [1:0] SizeHalf = 2'd1;
    localparam logic [1:0] SizeWord = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dc_mem_req_t;

endpackage

// File: rtl/dc_mem_ctrl_size_dec.sv
// Derives bus transfer size and direction from the byte write-enables (stores)
// or the requested load size (loads).
module dc_size_dec
    import dc_mem_pkg::*;
(
    input  logic [3:0] wen_i,
    input  logic [1:0] req_size_i,
    output logic [1:0] size_o,
    output logic       wr_o
);

    always_comb begin
        wr_o   = |wen_i;
        size_o = SizeWord;
        if (!wr_o) begin
            // The reserved load size 3 falls back to a word access.
            if (req_size_i != 2'd3) begin
                size_o = req_size_i;
            end
        end else begin
            case (wen_i)
                4'b0001, 4'b0010, 4'b0100, 4'b1000: size_o = SizeByte;
                4'b0011, 4'b1100:                   size_o = SizeHalf;
                default:                            size_o = SizeWord;
            endcase
        end
    end

endmodule

// File: rtl/dc_mem_ctrl.sv
// DC-stage data-memory sequencer: runs one SRAM-like bus transaction per request,
// stalls the pipeline while it is outstanding and drains accepted transfers on flush.
module dc_mem_ctrl
    import dc_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    input  logic [3:0]  req_wen,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stallreq,
    output logic [31:0] rdata_o,
    output logic        rdata_valid,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    dc_mem_state_e state_q, state_d;
    dc_mem_req_t   req_q, req_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    dec_size;
    logic          dec_wr;
    logic          capture;

    dc_size_dec u_size_dec (
        .wen_i      (req_wen),
        .req_size_i (req_size),
        .size_o     (dec_size),
        .wr_o       (dec_wr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DC_MEM_IDLE;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DC_MEM_IDLE: begin
                if (req_valid && !flush) state_d = DC_MEM_REQ;
            end
            DC_MEM_REQ: begin
                if (data_addr_ok && data_data_ok) begin
                    state_d = flush ? DC_MEM_IDLE : DC_MEM_DONE;
                end else if (data_addr_ok) begin
                    state_d = flush ? DC_MEM_DRAIN : DC_MEM_WAIT;
                end else if (flush) begin
                    state_d = DC_MEM_IDLE;
                end
            end
            DC_MEM_WAIT: begin
                if (data_data_ok) begin
                    state_d = flush ? DC_MEM_IDLE : DC_MEM_DONE;
                end else if (flush) begin
                    state_d = DC_MEM_DRAIN;
                end
            end
            DC_MEM_DONE: state_d = DC_MEM_IDLE;
            DC_MEM_DRAIN: begin
                if (data_data_ok) state_d = DC_MEM_IDLE;
            end
            default: state_d = DC_MEM_IDLE;
        endcase
    end

    // Fields are frozen from capture until the next request, so the bus sees them stable.
    assign capture = (state_q == DC_MEM_IDLE) && req_valid && !flush;

    always_comb begin
        req_d   = req_q;
        rdata_d = rdata_q;
        if (capture) begin
            req_d.wr    = dec_wr;
            req_d.size  = dec_size;
            req_d.wstrb = req_wen;
            req_d.addr  = req_addr;
            req_d.wdata = req_wdata;
        end
        if (state_d == DC_MEM_DONE) begin
            rdata_d = data_rdata;
        end
    end

    always_comb begin
        data_req    = 1'b0;
        rdata_valid = 1'b0;
        stallreq    = 1'b0;
        case (state_q)
            DC_MEM_IDLE:  stallreq = req_valid && !flush;
            DC_MEM_REQ: begin
                data_req = 1'b1;
                stallreq = 1'b1;
            end
            DC_MEM_WAIT:  stallreq = 1'b1;
            DC_MEM_DONE:  rdata_valid = 1'b1;
            DC_MEM_DRAIN: stallreq = req_valid;
            default: ;
        endcase
    end

    assign data_wr    = req_q.wr;
    assign data_size  = req_q.size;
    assign data_wstrb = req_q.wstrb;
    assign data_addr  = req_q.addr;
    assign data_wdata = req_q.wdata;
    assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_dc_mem_ctrl.sv
// Bench for dc_mem_ctrl: directed cycle tables, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_dc_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic [3:0]  req_wen;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stallreq;
    logic [31:0] rdata_o;
    logic        rdata_valid;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int total = 0;
    int bad   = 0;

    dc_mem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_wen      (req_wen),
        .req_size     (req_size),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stallreq     (stallreq),
        .rdata_o      (rdata_o),
        .rdata_valid  (rdata_valid),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

    typedef struct {
        bit          fl;
        bit          rv;
        logic [3:0]  wen;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        bit          aok;
        bit          dok;
        logic [31:0] rd;
        bit          e_stall;
        bit          e_req;
        bit          e_rv;
        bit          e_crd;
        logic [31:0] e_rdata;
        bit          e_wr;
        logic [1:0]  e_size;
        logic [3:0]  e_wstrb;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit fl, input bit rv, input logic [3:0] wen,
                         input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                         input bit aok, input bit dok, input logic [31:0] rd);
        rst          = r;
        flush        = fl;
        req_valid    = rv;
        req_wen      = wen;
        req_size     = sz;
        req_addr     = a;
        req_wdata    = wd;
        data_addr_ok = aok;
        data_data_ok = dok;
        data_rdata   = rd;
    endtask

    function automatic void add(input bit fl, input bit rv, input logic [3:0] wen, input logic [1:0] sz,
                                input logic [31:0] a, input logic [31:0] wd, input bit aok, input bit dok,
                                input logic [31:0] rd, input bit es, input bit er, input bit ev, input bit ecrd,
                                input logic [31:0] erd, input bit ewr, input logic [1:0] esz, input logic [3:0] ewst);
        vec_t v;
        v.fl = fl; v.rv = rv; v.wen = wen; v.sz = sz; v.a = a; v.wd = wd;
        v.aok = aok; v.dok = dok; v.rd = rd;
        v.e_stall = es; v.e_req = er; v.e_rv = ev; v.e_crd = ecrd; v.e_rdata = erd;
        v.e_wr = ewr; v.e_size = esz; v.e_wstrb = ewst;
        vq.push_back(v);
    endfunction

    function automatic logic [1:0] ref_size(input logic [3:0] wen, input logic [1:0] sz);
        if (wen == 4'd0) return (sz == 2'd3) ? 2'd2 : sz;
        if ($countones(wen) == 1) return 2'd0;
        if (wen == 4'b0011 || wen == 4'b1100) return 2'd1;
        return 2'd2;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, " stall"}, stallreq, 0);
        chk({tag, " rvalid"}, rdata_valid, 0);
        chk({tag, " rdata"}, rdata_o, 0);
        chk({tag, " req"}, data_req, 0);
        chk({tag, " wr"}, data_wr, 0);
        chk({tag, " size"}, data_size, 0);
        chk({tag, " wstrb"}, data_wstrb, 0);
        chk({tag, " addr"}, data_addr, 0);
        chk({tag, " wdata"}, data_wdata, 0);
    endtask

    // reference model and slave bookkeeping
    bit          m_busreq, m_out, m_done, m_drain, m_wr, sl_out;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata, m_rdata;

    initial begin
        logic [3:0] wtab [10];
        wtab = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

        // word load
        add(0,1,4'h0,2,32'h8000_0010,0,0,0,0,            1,0,0,0,0,          0,0,0);
        add(0,1,4'h0,2,32'h8000_0010,0,1,0,0,            1,1,0,0,0,          0,2,4'h0);
        add(0,1,4'h0,2,32'h8000_0010,0,0,1,32'hDEADBEEF, 1,0,0,0,0,          0,0,0);
        add(0,1,4'h0,2,32'h8000_0010,0,0,0,0,            0,0,1,1,32'hDEADBEEF,0,0,0);
        add(0,0,4'h0,0,0,0,0,0,0,                        0,0,0,0,0,          0,0,0);
        // half store, addr_ok and data_ok together
        add(0,1,4'hC,0,32'h0000_1002,32'h1234_0000,0,0,0,    1,0,0,0,0, 0,0,0);
        add(0,1,4'hC,0,32'h0000_1002,32'h1234_0000,1,1,32'h77,1,1,0,0,0, 1,1,4'hC);
        add(0,1,4'hC,0,32'h0000_1002,32'h1234_0000,0,0,0,    0,0,1,0,0, 0,0,0);
        add(0,0,4'h0,0,0,0,0,0,0,                            0,0,0,0,0, 0,0,0);
        // flush in REQ without addr_ok
        add(0,1,4'h0,0,32'h3,0,0,0,0,  1,0,0,0,0, 0,0,0);
        add(1,1,4'h0,0,32'h3,0,0,0,0,  1,1,0,0,0, 0,0,4'h0);
        add(0,0,4'h0,0,0,0,0,0,0,      0,0,0,0,0, 0,0,0);
        add(0,0,4'h0,0,0,0,0,0,0,      0,0,0,0,0, 0,0,0);
        // flush in WAIT, new request during drain
        add(0,1,4'h0,2,32'h2000_0008,0,0,0,0,            1,0,0,0,0, 0,0,0);
        add(0,1,4'h0,2,32'h2000_0008,0,1,0,0,            1,1,0,0,0, 0,2,4'h0);
        add(1,1,4'h0,2,32'h2000_0008,0,0,0,0,            1,0,0,0,0, 0,0,0);
        add(0,1,4'h0,1,32'h40,0,0,0,0,                   1,0,0,0,0, 0,0,0);
        add(0,1,4'h0,1,32'h40,0,0,0,0,                   1,0,0,0,0, 0,0,0);
        add(0,1,4'h0,1,32'h40,0,0,1,32'hBAD0_BAD0,       1,0,0,0,0, 0,0,0);
        add(0,1,4'h0,1,32'h40,0,0,0,0,                   1,0,0,0,0, 0,0,0);
        add(0,1,4'h0,1,32'h40,0,1,1,32'h5555_AAAA,       1,1,0,0,0, 0,1,4'h0);
        add(0,1,4'h0,1,32'h40,0,0,0,0,                   0,0,1,1,32'h5555_AAAA, 0,0,0);
        add(0,0,4'h0,0,0,0,0,0,0,                        0,0,0,0,0, 0,0,0);

        // reset
        drive(1,0,0,0,0,0,0,0,0,0);
        repeat (2) @(posedge clk);
        #1;
        drive(0,0,0,0,0,0,0,0,0,0);
        #1;
        chk_all_zero("reset");

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk); #1;
            drive(0, vq[i].fl, vq[i].rv, vq[i].wen, vq[i].sz, vq[i].a, vq[i].wd,
                  vq[i].aok, vq[i].dok, vq[i].rd);
            #1;
            chk($sformatf("v%0d stall", i), stallreq, vq[i].e_stall);
            chk($sformatf("v%0d req", i), data_req, vq[i].e_req);
            chk($sformatf("v%0d rvalid", i), rdata_valid, vq[i].e_rv);
            if (vq[i].e_crd) chk($sformatf("v%0d rdata", i), rdata_o, vq[i].e_rdata);
            if (vq[i].e_req) begin
                chk($sformatf("v%0d addr", i), data_addr, vq[i].a);
                chk($sformatf("v%0d wdata", i), data_wdata, vq[i].wd);
                chk($sformatf("v%0d wr", i), data_wr, vq[i].e_wr);
                chk($sformatf("v%0d size", i), data_size, vq[i].e_size);
                chk($sformatf("v%0d wstrb", i), data_wstrb, vq[i].e_wstrb);
            end
        end

        // back-pressure: addr_ok held low for four REQ cycles
        @(posedge clk); #1;
        drive(0,0,1,4'h0,2,32'h1000_0ABC,0,0,0,0); #1;
        chk("bp c0 stall", stallreq, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            drive(0,0,1,4'h0,2,32'h1000_0ABC,0,(k == 4),0,0); #1;
            chk($sformatf("bp r%0d req", k), data_req, 1);
            chk($sformatf("bp r%0d addr", k), data_addr, 32'h1000_0ABC);
            chk($sformatf("bp r%0d stall", k), stallreq, 1);
        end
        @(posedge clk); #1;
        drive(0,0,1,4'h0,2,32'h1000_0ABC,0,0,1,32'h0BAD_F00D); #1;
        chk("bp wait stall", stallreq, 1);
        chk("bp wait req", data_req, 0);
        @(posedge clk); #1;
        drive(0,0,1,4'h0,2,32'h1000_0ABC,0,0,0,0); #1;
        chk("bp done rvalid", rdata_valid, 1);
        chk("bp done rdata", rdata_o, 32'h0BAD_F00D);
        chk("bp done stall", stallreq, 0);

        // reset while a store sits in WAIT
        @(posedge clk); #1;
        drive(0,0,1,4'hF,0,32'h0000_00F0,32'hCAFE_F00D,0,0,0); #1;
        @(posedge clk); #1;
        drive(0,0,1,4'hF,0,32'h0000_00F0,32'hCAFE_F00D,1,0,0); #1;
        chk("rst req", data_req, 1);
        chk("rst wr", data_wr, 1);
        @(posedge clk); #1;
        drive(1,0,0,0,0,0,0,0,0,0); #1;
        chk("rst wait stall", stallreq, 1);
        @(posedge clk); #1;
        drive(0,0,0,0,0,0,0,0,0,0); #1;
        chk_all_zero("rst mid-wait");
        @(posedge clk); #1;
        drive(0,0,1,4'h0,2,32'h44,0,0,0,0); #1;
        chk("post-rst idle stall", stallreq, 1);
        chk("post-rst idle req", data_req, 0);
        @(posedge clk); #1;
        drive(0,0,1,4'h0,2,32'h44,0,1,1,32'h1111_2222); #1;
        chk("post-rst req", data_req, 1);
        chk("post-rst addr", data_addr, 32'h44);
        @(posedge clk); #1;
        drive(0,0,0,0,0,0,0,0,0,0); #1;
        chk("post-rst rdata", rdata_o, 32'h1111_2222);

        // randomized run against the reference model
        m_busreq = 0; m_out = 0; m_done = 0; m_drain = 0; sl_out = 0;
        m_wr = 0; m_size = 0; m_wstrb = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
        for (int c = 0; c < 4000; c++) begin
            bit          rv, fl, aok, dok, es;
            bit          n_busreq, n_out, n_done, n_drain;
            logic [3:0]  wen;
            logic [1:0]  sz;
            logic [31:0] a, wd, rd;
            @(posedge clk); #1;
            rv  = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            wen = ($urandom_range(0, 9) == 0) ? 4'($urandom) : wtab[$urandom_range(0, 9)];
            sz  = 2'($urandom_range(0, 3));
            a   = $urandom;
            wd  = $urandom;
            rd  = $urandom;
            aok = data_req && ($urandom_range(0, 2) == 0);
            dok = (sl_out && ($urandom_range(0, 2) == 0)) || (aok && ($urandom_range(0, 1) == 0));
            drive(0, fl, rv, wen, sz, a, wd, aok, dok, rd);
            #1;

            if (m_done)                  es = 0;
            else if (m_drain)            es = rv;
            else if (m_busreq || m_out)  es = 1;
            else                         es = rv && !fl;
            chk($sformatf("r%0d stall", c), stallreq, es);
            chk($sformatf("r%0d req", c), data_req, m_busreq);
            chk($sformatf("r%0d rvalid", c), rdata_valid, m_done);
            if (m_busreq) begin
                chk($sformatf("r%0d addr", c), data_addr, m_addr);
                chk($sformatf("r%0d wdata", c), data_wdata, m_wdata);
                chk($sformatf("r%0d wr", c), data_wr, m_wr);
                chk($sformatf("r%0d size", c), data_size, m_size);
                chk($sformatf("r%0d wstrb", c), data_wstrb, m_wstrb);
            end
            if (m_done && !m_wr) chk($sformatf("r%0d rdata", c), rdata_o, m_rdata);

            n_busreq = 0; n_out = 0; n_done = 0; n_drain = 0;
            if (m_done) begin
            end else if (m_drain) begin
                n_drain = !dok;
            end else if (m_busreq) begin
                if (aok && dok) begin
                    if (!fl) begin n_done = 1; m_rdata = rd; end
                end else if (aok) begin
                    if (fl) n_drain = 1; else n_out = 1;
                end else if (!fl) begin
                    n_busreq = 1;
                end
            end else if (m_out) begin
                if (dok) begin
                    if (!fl) begin n_done = 1; m_rdata = rd; end
                end else if (fl) n_drain = 1;
                else n_out = 1;
            end else if (rv && !fl) begin
                n_busreq = 1;
                m_addr   = a;
                m_wdata  = wd;
                m_wstrb  = wen;
                m_wr     = (wen != 0);
                m_size   = ref_size(wen, sz);
            end
            m_busreq = n_busreq; m_out = n_out; m_done = n_done; m_drain = n_drain;
            if (dok) sl_out = 0;
            else if (aok) sl_out = 1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
